// File: rtl/mezcladora_pkg.sv
// Shared types and default parameters for the mezcladora_multi mixer controller.
// The optional fill watchdog is enabled by defining MEZCLA_FILL_WDT_EN.
package mezcladora_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    MIX   = 3'd2,
    DRAIN = 3'd3,
    WAIT  = 3'd4,
    FAULT = 3'd5
  } state_e;

  localparam int N_CH_DEF         = 2;
  localparam int CNT_W_DEF        = 8;
  localparam int DRAIN_CYCLES_DEF = 16;
  localparam int FILL_TIMEOUT_DEF = 200;

  // A single channel still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mezcladora_timer.sv
// Loadable down-counter; tc flags the last cycle of a loaded duration (count == 1).
module mezcladora_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the counter rests at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == W'(1));

endmodule

// File: rtl/mezcladora_multi.sv
// N-channel fill / counted mix / timed drain / empty-wait sequencer.
// Define MEZCLA_FILL_WDT_EN to add the FILL watchdog and the FAULT state.
module mezcladora_multi
  import mezcladora_pkg::*;
#(
  parameter int N_CH         = N_CH_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             SeqMode,
  input  logic [CNT_W-1:0] MixCycles,
  input  logic [N_CH-1:0]  Level,
  input  logic             Empty,
  output logic [N_CH-1:0]  Valve,
  output logic             Drain,
  output logic             Motor,
  output logic             Beep,
  output logic             Wait,
  output logic             Fault
);

  localparam int IDX_W = idx_width(N_CH);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
    $error("mezcladora_multi: N_CH must be in 1..8");
  end
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES >= (1 << CNT_W)) begin : g_bad_drain
    $error("mezcladora_multi: DRAIN_CYCLES must be in 1..2^CNT_W-1");
  end
  if (FILL_TIMEOUT < 1) begin : g_bad_timeout
    $error("mezcladora_multi: FILL_TIMEOUT must be at least 1");
  end

  state_e            state_q, state_d;
  logic [N_CH-1:0]   done_q, done_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              seq_q, seq_d;
  logic [CNT_W-1:0]  mix_len_q, mix_len_d;
  logic              first_q, first_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_dec;
  logic              tmr_tc;
  logic [N_CH-1:0]   fill_hit;

  // One counter serves both MIX and DRAIN since the phases never overlap.
  mezcladora_timer #(.W(CNT_W)) u_phase_timer (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .tc       (tmr_tc)
  );

`ifdef MEZCLA_FILL_WDT_EN
  localparam int WDT_W = $clog2(FILL_TIMEOUT + 1);

  logic wdt_load;
  logic wdt_dec;
  logic wdt_tc;

  mezcladora_timer #(.W(WDT_W)) u_fill_wdt (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (wdt_load),
    .load_val (WDT_W'(FILL_TIMEOUT)),
    .dec      (wdt_dec),
    .tc       (wdt_tc)
  );
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      done_q    <= '0;
      idx_q     <= '0;
      seq_q     <= 1'b0;
      mix_len_q <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      mix_len_q <= mix_len_d;
      first_q   <= first_d;
    end
  end

  assign fill_hit = Level & Valve;

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    mix_len_d = mix_len_q;
    tmr_load  = 1'b0;
    tmr_val   = mix_len_q;
    tmr_dec   = 1'b0;
`ifdef MEZCLA_FILL_WDT_EN
    wdt_load  = 1'b0;
    wdt_dec   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = FILL;
          seq_d     = SeqMode;
          mix_len_d = (MixCycles == '0) ? CNT_W'(1) : MixCycles;
          done_d    = '0;
          idx_d     = '0;
`ifdef MEZCLA_FILL_WDT_EN
          wdt_load  = 1'b1;
`endif
        end
      end

      FILL: begin
        // A channel only counts as filled while its valve is actually open.
        done_d = done_q | fill_hit;
        if (seq_q && (fill_hit != '0)) begin
          idx_d = idx_q + IDX_W'(1);
        end
`ifdef MEZCLA_FILL_WDT_EN
        wdt_dec = 1'b1;
`endif
        if (&done_d) begin
          state_d  = MIX;
          tmr_load = 1'b1;
          tmr_val  = mix_len_q;
        end
`ifdef MEZCLA_FILL_WDT_EN
        else if (wdt_tc) begin
          state_d = FAULT;
        end
`endif
      end

      MIX: begin
        tmr_dec = 1'b1;
        if (tmr_tc) begin
          state_d  = DRAIN;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(DRAIN_CYCLES);
        end
      end

      DRAIN: begin
        tmr_dec = 1'b1;
        if (tmr_tc) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (Empty) begin
          state_d = IDLE;
        end
      end

      FAULT: begin
`ifdef MEZCLA_FILL_WDT_EN
        if (Empty && Start) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase

    first_d = (state_d != state_q);
  end

  // Outputs decode only registered state, so reset clears them without a clock.
  always_comb begin
    Valve = '0;
    Drain = 1'b0;
    Motor = 1'b0;
    Beep  = 1'b0;
    Wait  = 1'b0;
    Fault = 1'b0;

    case (state_q)
      FILL: begin
        for (int i = 0; i < N_CH; i++) begin
          Valve[i] = ~done_q[i] & (~seq_q | (idx_q == IDX_W'(i)));
        end
        Motor = |done_q;
      end
      MIX: begin
        Motor = 1'b1;
        Beep  = first_q;
      end
      DRAIN: begin
        Motor = 1'b1;
        Drain = 1'b1;
        Beep  = first_q;
      end
      WAIT: begin
        Drain = 1'b1;
        Wait  = 1'b1;
      end
`ifdef MEZCLA_FILL_WDT_EN
      FAULT: begin
        Fault = 1'b1;
        Drain = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mezcladora_multi.sv
// Directed self-checking bench for mezcladora_multi (N_CH=3, DRAIN_CYCLES=4, FILL_TIMEOUT=10).
// Outputs are compared as {Fault, Wait, Beep, Motor, Drain, Valve[2:0]} on the falling edge.
module tb_mezcladora_multi;

  localparam int N_CH         = 3;
  localparam int CNT_W        = 8;
  localparam int DRAIN_CYCLES = 4;
  localparam int FILL_TIMEOUT = 10;

  logic             Clk;
  logic             Reset_n;
  logic             Start;
  logic             SeqMode;
  logic [CNT_W-1:0] MixCycles;
  logic [N_CH-1:0]  Level;
  logic             Empty;
  logic [N_CH-1:0]  Valve;
  logic             Drain;
  logic             Motor;
  logic             Beep;
  logic             Wait;
  logic             Fault;

  logic [7:0] outs;
  int checks;
  int errors;

  mezcladora_multi #(
    .N_CH         (N_CH),
    .CNT_W        (CNT_W),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .FILL_TIMEOUT (FILL_TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .SeqMode   (SeqMode),
    .MixCycles (MixCycles),
    .Level     (Level),
    .Empty     (Empty),
    .Valve     (Valve),
    .Drain     (Drain),
    .Motor     (Motor),
    .Beep      (Beep),
    .Wait      (Wait),
    .Fault     (Fault)
  );

  assign outs = {Fault, Wait, Beep, Motor, Drain, Valve};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic apply_stimulus(input logic start, input logic seq, input logic [CNT_W-1:0] mix,
                                input logic [N_CH-1:0] level, input logic empty);
    Start     = start;
    SeqMode   = seq;
    MixCycles = mix;
    Level     = level;
    Empty     = empty;
  endtask

  task automatic check_output(input string tag, input logic [7:0] expected);
    checks++;
    assert (outs === expected) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, outs, expected);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation did not finish in time");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    Reset_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 8'd0, 3'b000, 1'b0);

    #1 check_output("reset_t1", 8'h00);
    tick();
    tick();
    check_output("reset_held", 8'h00);
    Reset_n = 1'b1;
    tick();
    check_output("idle_after_reset", 8'h00);

    $display("[TB] parallel fill, MixCycles=5");
    apply_stimulus(1'b1, 1'b0, 8'd5, 3'b000, 1'b0);
    tick(); check_output("par_fill1", 8'h07);
    apply_stimulus(1'b0, 1'b0, 8'd5, 3'b001, 1'b0);
    tick(); check_output("par_done0", 8'h16);
    tick(); check_output("par_hold", 8'h16);
    apply_stimulus(1'b0, 1'b0, 8'd5, 3'b101, 1'b0);
    tick(); check_output("par_done2", 8'h12);
    apply_stimulus(1'b0, 1'b0, 8'd5, 3'b111, 1'b0);
    tick(); check_output("par_mix1", 8'h30);
    apply_stimulus(1'b0, 1'b0, 8'd5, 3'b000, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      tick(); check_output($sformatf("par_mix%0d", i), 8'h10);
    end
    tick(); check_output("par_drain1", 8'h38);
    for (int i = 2; i <= 4; i++) begin
      tick(); check_output($sformatf("par_drain%0d", i), 8'h18);
    end
    tick(); check_output("par_wait1", 8'h48);
    tick(); check_output("par_wait2", 8'h48);
    apply_stimulus(1'b1, 1'b0, 8'd5, 3'b000, 1'b1);
    tick(); check_output("par_empty_idle", 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'd5, 3'b000, 1'b0);
    tick(); check_output("par_start_in_wait_dropped", 8'h00);

    $display("[TB] sequential fill, MixCycles=0");
    apply_stimulus(1'b1, 1'b1, 8'd0, 3'b100, 1'b0);
    tick(); check_output("seq_v0", 8'h01);
    apply_stimulus(1'b0, 1'b1, 8'd0, 3'b100, 1'b0);
    tick(); check_output("seq_lvl2_ignored", 8'h01);
    apply_stimulus(1'b0, 1'b1, 8'd0, 3'b101, 1'b0);
    tick(); check_output("seq_v1", 8'h12);
    apply_stimulus(1'b0, 1'b1, 8'd0, 3'b110, 1'b0);
    tick(); check_output("seq_v2", 8'h14);
    tick(); check_output("seq_mix1", 8'h30);
    apply_stimulus(1'b1, 1'b1, 8'd0, 3'b000, 1'b0);
    tick(); check_output("mix_start_ignored", 8'h38);
    apply_stimulus(1'b0, 1'b1, 8'd0, 3'b000, 1'b0);
    tick(); check_output("seq_drain2", 8'h18);
    Reset_n = 1'b0;
    #1 check_output("async_reset", 8'h00);
    tick();
    tick(); check_output("reset_held2", 8'h00);
    Reset_n = 1'b1;
    tick(); check_output("idle_post_reset1", 8'h00);
    tick(); check_output("idle_post_reset2", 8'h00);

    $display("[TB] all levels high at start, MixCycles=2");
    apply_stimulus(1'b1, 1'b0, 8'd2, 3'b111, 1'b0);
    tick(); check_output("allhigh_fill", 8'h07);
    apply_stimulus(1'b0, 1'b0, 8'd2, 3'b111, 1'b0);
    tick(); check_output("allhigh_mix1", 8'h30);
    tick(); check_output("allhigh_mix2", 8'h10);
    tick(); check_output("allhigh_drain1", 8'h38);
    for (int i = 2; i <= 4; i++) begin
      tick(); check_output($sformatf("allhigh_drain%0d", i), 8'h18);
    end
    tick(); check_output("allhigh_wait", 8'h48);
    apply_stimulus(1'b0, 1'b0, 8'd2, 3'b000, 1'b1);
    tick(); check_output("allhigh_idle", 8'h00);

    $display("[TB] channel 2 never fills");
    apply_stimulus(1'b1, 1'b0, 8'd3, 3'b011, 1'b0);
    tick(); check_output("stall_fill1", 8'h07);
    apply_stimulus(1'b0, 1'b0, 8'd3, 3'b011, 1'b0);
    for (int i = 2; i <= 10; i++) begin
      tick(); check_output($sformatf("stall_fill%0d", i), 8'h14);
    end
`ifdef MEZCLA_FILL_WDT_EN
    tick(); check_output("wdt_fault", 8'h88);
    apply_stimulus(1'b1, 1'b0, 8'd3, 3'b011, 1'b0);
    tick(); check_output("fault_start_no_empty", 8'h88);
    apply_stimulus(1'b0, 1'b0, 8'd3, 3'b000, 1'b1);
    tick(); check_output("fault_empty_no_start", 8'h88);
    apply_stimulus(1'b1, 1'b0, 8'd3, 3'b000, 1'b1);
    tick(); check_output("fault_exit", 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'd3, 3'b000, 1'b0);
    tick(); check_output("fault_idle", 8'h00);
`else
    tick(); check_output("no_wdt_fill11", 8'h14);
    tick(); check_output("no_wdt_fill12", 8'h14);
    apply_stimulus(1'b0, 1'b0, 8'd3, 3'b111, 1'b0);
    tick(); check_output("no_wdt_mix1", 8'h30);
    tick(); check_output("no_wdt_mix2", 8'h10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mezcladora_multi.md
# mezcladora_multi

Parametrised successor to the two-ingredient mixer controller: sequences an N-channel fill, a counted mix, a timed drain and an empty-wait, all with internal down-counters instead of an external timer token. Sits between the tank sensor/actuator interface and the operator start button. Adds selectable sequential/parallel fill, a runtime mix duration, and an optional fill watchdog.

## Interface
- N_CH, 2, number of ingredient inlet channels (1..8)
- CNT_W, 8, width of the mix-duration input and the internal counter
- DRAIN_CYCLES, 16, timed drain length in clock cycles (≥1, < 2^CNT_W)
- FILL_TIMEOUT, 200, watchdog limit in cycles for the whole FILL phase (used only with the macro)
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  start request, honoured only in IDLE
- SeqMode  in  1  1 = fill channels one at a time in index order, 0 = all in parallel; sampled on Start
- MixCycles  in  CNT_W  mix duration in cycles; sampled on Start; 0 treated as 1
- Level  in  N_CH  Level[i]=1: channel i quantity reached
- Empty  in  1  tank empty sensor
- Valve  out  N_CH  inlet valve enables
- Drain  out  1  outlet valve
- Motor  out  1  mixer motor
- Beep  out  1  one-cycle indicator pulse
- Wait  out  1  high while waiting for Empty
- Fault  out  1  watchdog fault indication

## Operation
- States: IDLE, FILL, MIX, DRAIN, WAIT, FAULT (FAULT only reachable with the macro).
- Outputs are Moore: decoded from registered state, done-mask, current index and first-cycle flag. No clock gating in any output.
- IDLE: all outputs 0. Start=1 → FILL; latch SeqMode, max(MixCycles,1); clear done-mask; index=0.
- FILL: parallel: Valve[i] = ~done[i]. Sequential: Valve[i] = (i==index) & ~done[i]. done[i] sets on the edge Level[i] is sampled 1 while its valve is enabled. Sequential index advances on the same edge. Motor = 1 once any done bit is set.
- The edge that completes the done-mask moves to MIX and loads the counter with the latched duration.
- A Level already high on entry still produces exactly one cycle of that valve.
- MIX: Motor=1, for exactly the latched count of cycles; then DRAIN with counter = DRAIN_CYCLES.
- DRAIN: Motor=1, Drain=1, for exactly DRAIN_CYCLES cycles; then WAIT.
- WAIT: Drain=1, Wait=1, Motor=0. Empty sampled 1 → IDLE.
- Beep = 1 on the first cycle of MIX and the first cycle of DRAIN only.
- Start is ignored outside IDLE. Level changes outside FILL are ignored.
- Reset_n low at any time: state to IDLE and all registers cleared; all outputs 0 immediately, without waiting for a clock.

## Timing
- Start sampled at edge k → FILL from cycle k+1; a valve is high in cycle k+1.
- Level[last] sampled at edge m → MIX spans cycles m+1 … m+M; DRAIN spans the next DRAIN_CYCLES cycles; WAIT follows.
- Empty sampled at edge w in WAIT → IDLE in cycle w+1. A Start in that same cycle is not honoured.
- Counter arithmetic is unsigned CNT_W. The counter is loaded with the duration and the phase ends on the edge where it reads 1. No wrap-around occurs.

## Configuration
- MEZCLA_FILL_WDT_EN defined:
  - The watchdog counts cycles spent in FILL.
  - On reaching FILL_TIMEOUT without completion → FAULT.
  - FAULT outputs: Fault=1, Drain=1, Valve=0, Motor=0.
  - FAULT → IDLE when Empty=1 and Start=1 are sampled in the same cycle.
- Undefined: no watchdog, FILL is unbounded, Fault tied 0, and FAULT is unreachable.

## Structure
- Package mezcladora_pkg holds:
  - The state enum typedef: IDLE=0, FILL=1, MIX=2, DRAIN=3, WAIT=4, FAULT=5, 3 bits.
  - Default parameter constants.
- One sub-module, mezcladora_timer: a loadable CNT_W down-counter with a terminal flag. It is instantiated once for MIX/DRAIN, and once more for the watchdog when the macro is defined.

## Test plan
- N_CH=3, parallel, MixCycles=5, DRAIN_CYCLES=4, Levels rise at different times → Valve=3'b111 narrowing to 0; Motor from first done; MIX exactly 5 cycles; Beep at MIX+0 and DRAIN+0; Drain for 4 cycles then WAIT; Empty → IDLE.
- Sequential mode, N_CH=3 → Valve one-hot 001→010→100. Level[2] raised early is ignored until index=2.
- MixCycles=0 → MIX lasts 1 cycle. Start asserted during MIX → no effect.
- Reset_n pulsed low mid-DRAIN → all outputs 0 asynchronously. After release the block sits in IDLE until Start.
- Macro defined, FILL_TIMEOUT=10, one Level never rises → Fault=1 and Drain=1 at FILL cycle 10. Start without Empty → stays in FAULT. Start with Empty → IDLE.
- Level already all-high at Start → one cycle of every valve, then MIX.
